// File: rtl/m_imem_loader_if.sv
// Byte-stream in / imem write port out for the instruction-memory loader.
// The slave modport is the loader's view; the master modport is the host/byte-source view.
interface m_imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              w_clear;
    logic              w_rx_valid;
    logic [7:0]        w_rx_data;
    logic              w_rx_ready;
    logic              w_imem_we;
    logic [ADDR_W-1:0] w_imem_addr;
    logic [31:0]       w_imem_wdata;
    logic              w_cpu_run;
    logic              w_err;

    modport slave (
        input  w_clear,
        input  w_rx_valid,
        input  w_rx_data,
        output w_rx_ready,
        output w_imem_we,
        output w_imem_addr,
        output w_imem_wdata,
        output w_cpu_run,
        output w_err
    );

    modport master (
        output w_clear,
        output w_rx_valid,
        output w_rx_data,
        input  w_rx_ready,
        input  w_imem_we,
        input  w_imem_addr,
        input  w_imem_wdata,
        input  w_cpu_run,
        input  w_err
    );
endinterface

// File: rtl/m_imem_loader.sv
// Assembles LEN/payload/XOR-checksum byte frames into LE words; imem strobe 1 cycle after a word's 4th byte.
// Backpressure: rx_ready is high only in LEN0/LEN1/DATA/CSUM with no clear/reset; DONE and ERR stall the source.
module m_imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic          w_clk,
    input  logic          w_rst_n,
    m_imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [7:0]        csum_q, csum_d;
    logic [23:0]       shift_q, shift_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              run_q, run_d;
    logic              err_q, err_d;

    logic              rdy_state;
    logic              xfer;
    logic [15:0]       len_full;
    logic              last_word;

    assign rdy_state = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                       (state_q == S_DATA) || (state_q == S_CSUM);
    assign bus.w_rx_ready = rdy_state & ~bus.w_clear & w_rst_n;
    assign xfer      = bus.w_rx_valid & bus.w_rx_ready;

    // Full 16-bit length as it will be once the hi byte lands this cycle.
    assign len_full  = {bus.w_rx_data, len_q[7:0]};
    assign last_word = (word_idx_q == (len_q - 16'd1));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        csum_d     = csum_q;
        shift_d    = shift_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        run_d      = run_q;
        err_d      = err_q;

        if (bus.w_clear) begin
            state_d    = S_LEN0;
            len_d      = '0;
            byte_cnt_d = '0;
            word_idx_d = '0;
            csum_d     = '0;
            shift_d    = '0;
            run_d      = 1'b0;
            err_d      = 1'b0;
        end else if (xfer) begin
            unique case (state_q)
                S_LEN0: begin
                    len_d[7:0] = bus.w_rx_data;
                    state_d    = S_LEN1;
                end
                S_LEN1: begin
                    len_d = len_full;
                    if (len_full > DEPTH_W) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    csum_d = csum_q ^ bus.w_rx_data;
                    unique case (byte_cnt_q)
                        2'd0: shift_d[7:0]   = bus.w_rx_data;
                        2'd1: shift_d[15:8]  = bus.w_rx_data;
                        2'd2: shift_d[23:16] = bus.w_rx_data;
                        default: begin
                            we_d       = 1'b1;
                            addr_d     = word_idx_q[ADDR_W-1:0];
                            wdata_d    = {bus.w_rx_data, shift_q};
                            word_idx_d = word_idx_q + 16'd1;
                            if (last_word) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
                S_CSUM: begin
                    if (bus.w_rx_data == csum_q) begin
                        state_d = S_DONE;
                        run_d   = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // A strobe pending at reset is discarded along with the rest of the frame.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q    <= S_LEN0;
            len_q      <= '0;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            csum_q     <= '0;
            shift_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            run_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            csum_q     <= csum_d;
            shift_q    <= shift_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            run_q      <= run_d;
            err_q      <= err_d;
        end
    end

    assign bus.w_imem_we    = we_q;
    assign bus.w_imem_addr  = addr_q;
    assign bus.w_imem_wdata = wdata_q;
    assign bus.w_cpu_run    = run_q;
    assign bus.w_err        = err_q;

endmodule

// File: tb/tb_m_imem_loader.sv
// Scoreboarded bench for m_imem_loader: stimulus queues expected imem writes, a negedge monitor checks them.
module tb_m_imem_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        int                cyc;
    } exp_t;

    exp_t exp_q[$];

    m_imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    m_imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .w_clk   (clk),
        .w_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write, in the expected cycle.
    logic prev_we;
    initial prev_we = 1'b0;
    always @(negedge clk) begin
        if (bus.w_imem_we === 1'b1) begin
            if (prev_we) begin
                chk("we_back_to_back", 32'd1, 32'd0);
            end
            if (exp_q.size() == 0) begin
                chk("unexpected_we_addr", 32'(bus.w_imem_addr), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("we_addr", 32'(bus.w_imem_addr), 32'(e.addr));
                chk("we_wdata", bus.w_imem_wdata, e.wdata);
                chk("we_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        prev_we = (bus.w_imem_we === 1'b1);
    end

    // All drive tasks start and end at posedge+1.
    task automatic send_byte(input logic [7:0] b, input int gap, output int xcyc);
        bit ok;
        ok   = 1'b0;
        xcyc = -1;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.w_rx_valid = 1'b1;
        bus.w_rx_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.w_rx_ready === 1'b1) begin
                ok   = 1'b1;
                xcyc = cyc + 1;
                break;
            end
        end
        if (!ok) chk("rx_accept_timeout", 32'(b), 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        bus.w_rx_valid = 1'b0;
    endtask

    task automatic send_t1(input int gap_max, input logic [7:0] csum_byte);
        logic [7:0] fr [11];
        int         xc;
        exp_t       e;
        fr = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
               8'h13, 8'h81, 8'h10, 8'h00, 8'h41};
        fr[10] = csum_byte;
        for (int i = 0; i < 11; i++) begin
            send_byte(fr[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0, xc);
            if (i == 5) begin
                e.addr = 6'd0; e.wdata = 32'h0050_0093; e.cyc = xc;
                exp_q.push_back(e);
            end else if (i == 9) begin
                e.addr = 6'd1; e.wdata = 32'h0010_8113; e.cyc = xc;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_clear();
        bus.w_clear = 1'b1;
        @(negedge clk);
        chk("ready_low_during_clear", 32'(bus.w_rx_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.w_clear = 1'b0;
    endtask

    task automatic check_end(input string tag, input logic run, input logic err, input logic rdy);
        @(negedge clk);
        chk({tag, "_cpu_run"}, 32'(bus.w_cpu_run), 32'(run));
        chk({tag, "_err"}, 32'(bus.w_err), 32'(err));
        chk({tag, "_ready"}, 32'(bus.w_rx_ready), 32'(rdy));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  xc;
        bit  stayed_low;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.w_clear    = 1'b0;
        bus.w_rx_valid = 1'b0;
        bus.w_rx_data  = 8'h00;

        repeat (3) @(negedge clk);
        bus.w_rx_valid = 1'b1;
        #1;
        chk("rst_ready", 32'(bus.w_rx_ready), 32'd0);
        chk("rst_we", 32'(bus.w_imem_we), 32'd0);
        chk("rst_addr", 32'(bus.w_imem_addr), 32'd0);
        chk("rst_wdata", bus.w_imem_wdata, 32'd0);
        chk("rst_run", 32'(bus.w_cpu_run), 32'd0);
        chk("rst_err", 32'(bus.w_err), 32'd0);
        bus.w_rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_end("post_rst", 1'b0, 1'b0, 1'b1);

        // T1 valid load
        send_t1(0, 8'h41);
        check_end("t1", 1'b1, 1'b0, 1'b0);
        chk("t1_hold_addr", 32'(bus.w_imem_addr), 32'd1);
        chk("t1_hold_wdata", bus.w_imem_wdata, 32'h0010_8113);

        // T2 bad checksum
        do_clear();
        check_end("t2_clr", 1'b0, 1'b0, 1'b1);
        send_t1(0, 8'h42);
        check_end("t2", 1'b0, 1'b1, 1'b0);

        // T3 empty image
        do_clear();
        send_byte(8'h00, 0, xc);
        send_byte(8'h00, 0, xc);
        send_byte(8'h00, 0, xc);
        check_end("t3", 1'b1, 1'b0, 1'b0);

        // T4 oversize length (N = 65)
        do_clear();
        send_byte(8'h41, 0, xc);
        send_byte(8'h00, 0, xc);
        check_end("t4", 1'b0, 1'b1, 1'b0);
        bus.w_rx_valid = 1'b1;
        bus.w_rx_data  = 8'h55;
        stayed_low = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.w_rx_ready !== 1'b0) stayed_low = 1'b0;
        end
        chk("t4_no_accept", 32'(stayed_low), 32'd1);
        @(posedge clk);
        #1;
        bus.w_rx_valid = 1'b0;

        // T5 random stalls
        do_clear();
        send_t1(5, 8'h41);
        check_end("t5", 1'b1, 1'b0, 1'b0);

        // T6a abort with clear after 2 payload bytes
        do_clear();
        send_byte(8'h02, 0, xc);
        send_byte(8'h00, 0, xc);
        send_byte(8'h93, 0, xc);
        send_byte(8'h00, 0, xc);
        do_clear();
        check_end("t6a_clr", 1'b0, 1'b0, 1'b1);
        send_t1(0, 8'h41);
        check_end("t6a", 1'b1, 1'b0, 1'b0);

        // T6b abort with reset pulse after 2 payload bytes
        do_clear();
        send_byte(8'h02, 0, xc);
        send_byte(8'h00, 0, xc);
        send_byte(8'h93, 0, xc);
        send_byte(8'h00, 0, xc);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6b_ready_in_rst", 32'(bus.w_rx_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_end("t6b_rst", 1'b0, 1'b0, 1'b1);
        send_t1(0, 8'h41);
        check_end("t6b", 1'b1, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
